alu_seq: RTL and testbench

Parametrised multi-cycle ALU: the word-level successor of the 1-bit ALU slice, executing the same funct-coded operation set at WIDTH bits, plus an iterative logical shift and an iterative unsigned divide. It sits in the EX stage of the pipelined CPU. A start/busy/done handshake lets the hazard unit stall the pipeline while a multi-cycle operation runs. Single-cycle operations complete with one registered cycle of latency.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_div_step.sv | 27 ++
 rtl/alu_seq.sv | 151 +++++++++++++++
 tb/tb_alu_seq.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle ALU.
//   FN_*        funct codes understood by alu_seq
//   alu_state_t sequencer states
package alu_pkg;

  localparam logic [5:0] FN_AND  = 6'd36;
  localparam logic [5:0] FN_OR   = 6'd37;
  localparam logic [5:0] FN_ADD  = 6'd32;
  localparam logic [5:0] FN_SUB  = 6'd34;
  localparam logic [5:0] FN_SLT  = 6'd42;
  localparam logic [5:0] FN_SRL  = 6'd2;
  localparam logic [5:0] FN_DIVU = 6'd27;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DIV,
    FIN
  } alu_state_t;

endpackage

// File: rtl/alu_div_step.sv
// alu_div_step: one combinational restoring-divide iteration.
//   r_i, q_i  partial remainder / quotient before the step
//   b_i       divisor
//   r_o, q_o  partial remainder / quotient after the step
module alu_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] rs;
  logic           ge;

  always_comb begin
    // Shifted remainder needs one extra bit; the trial compare uses it, but the
    // restored remainder is always < b, so a WIDTH-bit subtract is exact.
    rs  = {r_i, q_i[WIDTH-1]};
    ge  = (rs >= {1'b0, b_i});
    r_o = ge ? (rs[WIDTH-1:0] - b_i) : rs[WIDTH-1:0];
    q_o = {q_i[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle WIDTH-bit ALU with start/busy/done handshake.
//   clk, rst_n      clock, async active-low reset
//   start           request, accepted only when idle
//   signal          funct code (AND/OR/ADD/SUB/SLT/SRL/DIVU, others = ADD)
//   a, b, shamt     operands, sampled on the accepting edge
//   result, rem     result / quotient and DIVU remainder
//   zero, ovf       result==0, signed overflow (ADD/SUB)
//   busy, done      operation in flight, one-cycle completion pulse
module alu_seq
  import alu_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       signal,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] rem,
  output logic             zero,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam logic [SHW:0] CNT_DIV = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE = {{SHW{1'b0}}, 1'b1};

  alu_state_t       state_q;
  logic [SHW:0]     cnt_q;
  logic [WIDTH-1:0] wq_q;    // shift value / quotient / single-cycle result
  logic [WIDTH-1:0] wr_q;    // divide partial remainder
  logic [WIDTH-1:0] b_q;
  logic             wovf_q;

  logic [WIDTH-1:0] result_q, rem_q;
  logic             zero_q, ovf_q, busy_q, done_q;

  logic [WIDTH-1:0] alu_d, sum, diff;
  logic             aovf_d;
  logic [WIDTH-1:0] div_r_d, div_q_d;

  always_comb begin
    sum    = a + b;
    diff   = a - b;
    alu_d  = sum;
    aovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    case (signal)
      FN_AND: begin alu_d = a & b; aovf_d = 1'b0; end
      FN_OR:  begin alu_d = a | b; aovf_d = 1'b0; end
      FN_SUB: begin
        alu_d  = diff;
        aovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      FN_SLT: begin
        // Direct signed compare, immune to a-b overflow.
        alu_d    = '0;
        alu_d[0] = ($signed(a) < $signed(b));
        aovf_d   = 1'b0;
      end
      default: ;
    endcase
  end

  alu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .r_i (wr_q),
    .q_i (wq_q),
    .b_i (b_q),
    .r_o (div_r_d),
    .q_o (div_q_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wq_q     <= '0;
      wr_q     <= '0;
      b_q      <= '0;
      wovf_q   <= 1'b0;
      result_q <= '0;
      rem_q    <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            b_q    <= b;
            wr_q   <= '0;
            wovf_q <= 1'b0;
            case (signal)
              FN_SRL: begin
                wq_q    <= a;
                cnt_q   <= {1'b0, shamt};
                state_q <= (shamt == '0) ? FIN : SHIFT;
              end
              FN_DIVU: begin
                wq_q    <= a;
                cnt_q   <= CNT_DIV;
                state_q <= DIV;
              end
              default: begin
                wq_q    <= alu_d;
                wovf_q  <= aovf_d;
                state_q <= FIN;
              end
            endcase
          end
        end
        SHIFT: begin
          wq_q  <= wq_q >> 1;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_q <= FIN;
        end
        DIV: begin
          wq_q  <= div_q_d;
          wr_q  <= div_r_d;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_q <= FIN;
        end
        FIN: begin
          result_q <= wq_q;
          rem_q    <= wr_q;
          zero_q   <= (wq_q == '0);
          ovf_q    <= wovf_q;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign rem    = rem_q;
  assign zero   = zero_q;
  assign ovf    = ovf_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  localparam logic [5:0] F_AND = 6'd36, F_OR = 6'd37, F_ADD = 6'd32, F_SUB = 6'd34,
                         F_SLT = 6'd42, F_SRL = 6'd2, F_DIVU = 6'd27;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] rem;
    logic        zero;
    logic        ovf;
    logic [7:0]  lat;
  } out_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  signal;
  logic [31:0] a, b;
  logic [4:0]  shamt;
  logic [31:0] result, rem;
  logic        zero, ovf, busy, done;

  int   total = 0;
  int   bad   = 0;
  out_t sb[$];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .signal (signal),
    .a      (a),
    .b      (b),
    .shamt  (shamt),
    .result (result),
    .rem    (rem),
    .zero   (zero),
    .ovf    (ovf),
    .busy   (busy),
    .done   (done)
  );

  function automatic out_t model(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y,
                                 input logic [4:0] sh);
    out_t        m;
    logic [31:0] r;
    m     = '0;
    m.lat = 8'd1;
    case (op)
      F_AND: r = x & y;
      F_OR:  r = x | y;
      F_SUB: begin
        r     = x - y;
        m.ovf = (x[31] != y[31]) && (r[31] != x[31]);
      end
      F_SLT: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      F_SRL: begin
        r     = x >> sh;
        m.lat = {3'b000, sh} + 8'd1;
      end
      F_DIVU: begin
        if (y == 32'd0) begin
          r     = 32'hFFFF_FFFF;
          m.rem = x;
        end else begin
          r     = x / y;
          m.rem = x % y;
        end
        m.lat = 8'd33;
      end
      default: begin
        r     = x + y;
        m.ovf = (x[31] == y[31]) && (r[31] != x[31]);
      end
    endcase
    m.res  = r;
    m.zero = (r == 32'd0);
    return m;
  endfunction

  // Drives one request, waits (bounded) for done and returns what the DUT
  // produced plus the observed latency. inject_at>0 raises a stray AND start
  // for one cycle that many edges after acceptance.
  task automatic run_op(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] sh, input int inject_at,
                        output out_t o, output int busy_bad);
    bit got;
    int lat;
    @(negedge clk);
    start = 1'b1; signal = op; a = x; b = y; shamt = sh;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; shamt = 5'($urandom);
    got = 0; lat = 0; busy_bad = 0;
    for (int c = 1; c <= 100 && !got; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        got = 1; lat = c;
        if (busy !== 1'b0) busy_bad++;
      end else begin
        if (busy !== 1'b1) busy_bad++;
        if (c == inject_at) begin
          start = 1'b1; signal = F_AND; a = 32'hFFFF_0000; b = 32'h0F0F_0F0F;
        end else start = 1'b0;
      end
    end
    start  = 1'b0;
    o.res  = result;
    o.rem  = rem;
    o.zero = zero;
    o.ovf  = ovf;
    o.lat  = got ? 8'(lat) : 8'hFF;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; signal = '0; a = '0; b = '0; shamt = '0;
    #3;
    total++;
    if ({result, rem, zero, ovf, busy, done} !== 68'd0) begin
      bad++;
      $display("FAIL reset: got res=%h rem=%h z=%b v=%b busy=%b done=%b want all 0",
               result, rem, zero, ovf, busy, done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    logic [5:0]  ops[3] = '{F_ADD, F_SUB, F_SLT};
    logic [31:0] xs[3]  = '{32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFF};
    logic [31:0] ys[3]  = '{32'd1, 32'd5, 32'd1};
    out_t o, e;
    int   bb;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(model(ops[i], xs[i], ys[i], 5'd0));
      run_op(ops[i], xs[i], ys[i], 5'd0, 0, o, bb);
      e = sb.pop_front();
      total++;
      if (o !== e || bb != 0) begin
        bad++;
        $display("FAIL alu[%0d]: got res=%h rem=%h z=%b v=%b lat=%0d busyerr=%0d want res=%h rem=%h z=%b v=%b lat=%0d busyerr=0",
                 i, o.res, o.rem, o.zero, o.ovf, o.lat, bb, e.res, e.rem, e.zero, e.ovf, e.lat);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({result, zero, done} !== {32'd1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL hold: got res=%h z=%b done=%b want res=00000001 z=0 done=0", result, zero, done);
    end
  endtask

  task automatic test_srl();
    logic [31:0] xs[3] = '{32'h8000_0000, 32'hDEAD_BEEF, 32'hF000_000F};
    logic [4:0]  ss[3] = '{5'd31, 5'd0, 5'd4};
    out_t o, e;
    int   bb;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(model(F_SRL, xs[i], 32'h1234_5678, ss[i]));
      run_op(F_SRL, xs[i], 32'h1234_5678, ss[i], 0, o, bb);
      e = sb.pop_front();
      total++;
      if (o !== e || bb != 0) begin
        bad++;
        $display("FAIL srl[%0d]: got res=%h rem=%h z=%b v=%b lat=%0d busyerr=%0d want res=%h rem=%h z=%b v=%b lat=%0d busyerr=0",
                 i, o.res, o.rem, o.zero, o.ovf, o.lat, bb, e.res, e.rem, e.zero, e.ovf, e.lat);
      end
    end
  endtask

  task automatic test_divu();
    logic [31:0] xs[4] = '{32'd100, 32'd9, 32'hFFFF_FFFF, 32'd3};
    logic [31:0] ys[4] = '{32'd7, 32'd0, 32'd1, 32'hFFFF_FFF0};
    out_t o, e;
    int   bb;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(model(F_DIVU, xs[i], ys[i], 5'd0));
      run_op(F_DIVU, xs[i], ys[i], 5'd0, 0, o, bb);
      e = sb.pop_front();
      total++;
      if (o !== e || bb != 0) begin
        bad++;
        $display("FAIL divu[%0d]: got res=%h rem=%h z=%b v=%b lat=%0d busyerr=%0d want res=%h rem=%h z=%b v=%b lat=%0d busyerr=0",
                 i, o.res, o.rem, o.zero, o.ovf, o.lat, bb, e.res, e.rem, e.zero, e.ovf, e.lat);
      end
    end
  endtask

  task automatic test_busy_ignore();
    out_t o, e;
    int   bb;
    sb.push_back(model(F_DIVU, 32'd1000, 32'd33, 5'd0));
    run_op(F_DIVU, 32'd1000, 32'd33, 5'd0, 5, o, bb);
    e = sb.pop_front();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL busy_ignore: got res=%h rem=%h lat=%0d want res=%h rem=%h lat=%0d",
               o.res, o.rem, o.lat, e.res, e.rem, e.lat);
    end
    total++;
    if (bb != 0) begin
      bad++;
      $display("FAIL busy_hold: got %0d busy errors want 0", bb);
    end
  endtask

  task automatic test_reset_abort();
    out_t o, e;
    int   bb;
    int   seen;
    @(negedge clk);
    start = 1'b1; signal = F_DIVU; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({result, rem, zero, ovf, busy, done} !== 68'd0) begin
      bad++;
      $display("FAIL abort_clear: got res=%h rem=%h z=%b v=%b busy=%b done=%b want all 0",
               result, rem, zero, ovf, busy, done);
    end
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL abort_nodone: got %0d cycles with done/busy high want 0", seen);
    end
    sb.push_back(model(F_ADD, 32'd2, 32'd3, 5'd0));
    run_op(F_ADD, 32'd2, 32'd3, 5'd0, 0, o, bb);
    e = sb.pop_front();
    total++;
    if (o !== e || bb != 0) begin
      bad++;
      $display("FAIL abort_add: got res=%h lat=%0d busyerr=%0d want res=%h lat=%0d busyerr=0",
               o.res, o.lat, bb, e.res, e.lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  tbl[9] = '{F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SRL, F_DIVU, 6'd0, 6'd63};
    logic [5:0]  op;
    logic [31:0] x, y;
    logic [4:0]  sh;
    out_t        o, e;
    int          bb;
    for (int i = 0; i < 14; i++) begin
      op = tbl[i % 9];
      x  = $urandom;
      y  = (i % 3 == 0) ? x : 32'($urandom);
      sh = 5'($urandom_range(0, 7));
      sb.push_back(model(op, x, y, sh));
      run_op(op, x, y, sh, 0, o, bb);
      e = sb.pop_front();
      total++;
      if (o !== e || bb != 0) begin
        bad++;
        $display("FAIL b2b[%0d] op=%0d: got res=%h rem=%h z=%b v=%b lat=%0d busyerr=%0d want res=%h rem=%h z=%b v=%b lat=%0d busyerr=0",
                 i, op, o.res, o.rem, o.zero, o.ovf, o.lat, bb, e.res, e.rem, e.zero, e.ovf, e.lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_srl();
    test_divu();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
